sti_cmd_scheduler: RTL and testbench

Command scheduler in front of the serial transmitter / data-arrange block. It accepts STI transfer commands from two requesters and arbitrates them round-robin into a small FIFO. It drives the transmitter's parallel inputs (`load`, `pi_*`) one command at a time, holding them stable for the full transfer. On flush it drains the queue, raises `pi_end` until `pixel_finish`, and cross-checks the serial bit count against `so_valid`.

---
 rtl/sti_cmd_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sti_cmd_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_cmd_scheduler.sv
// STI command scheduler: round-robin arbiter, command FIFO and issue FSM
// driving the serial transmitter parallel inputs.
module sti_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [20:0] cmd_a,
  input  logic [20:0] cmd_b,
  output logic        gnt_a,
  output logic        gnt_b,
  input  logic        flush,
  input  logic        so_valid,
  input  logic        pixel_finish,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [5:0] GAP_LAST =
    6'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [20:0]   mem_q [FIFO_DEPTH];
  logic [20:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          prio_q, prio_d;
  logic          flush_q, flush_d;
  logic          err_q, err_d;
  logic [2:0]    state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    vcnt_q, vcnt_d;
  logic [20:0]   pi_q, pi_d;

  logic          can_gnt;
  logic          push;
  logic          pop;
  logic [20:0]   wdata;
  logic [2:0]    lenp1;
  logic [5:0]    nbits;
  logic [5:0]    hold_last;
  logic [5:0]    vsum;

  // reset gates the grant so nothing is acknowledged while held
  assign can_gnt = reset && (count_q != FULL) && !flush_q
                   && (state_q != S_DONE);
  assign gnt_a = can_gnt && req_a && (!req_b || !prio_q);
  assign gnt_b = can_gnt && req_b && (!req_a || prio_q);
  assign push  = gnt_a || gnt_b;
  assign wdata = gnt_a ? cmd_a : cmd_b;
  assign pop   = (state_q == S_IDLE) && (count_q != '0);

  assign lenp1     = {1'b0, pi_q[20:19]} + 3'd1;
  assign nbits     = {lenp1, 3'b000};
  assign hold_last = nbits + 6'd1;
  assign vsum      = vcnt_q + {5'b0, so_valid};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    flush_d  = flush_q | flush;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = wr_ptr_q + PW'(1);
      prio_d   = ~prio_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) count_d = count_q + (PW+1)'(1);
    if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vcnt_d  = vcnt_q;
    err_d   = err_q;
    pi_d    = pi_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          pi_d    = mem_q[rd_ptr_q];
          state_d = S_LOAD;
        end else if (flush_q) begin
          state_d = S_END;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        vcnt_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        vcnt_d = vsum;
        if (cnt_q == hold_last) begin
          if (vsum != nbits) err_d = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYC > 1) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      // the IDLE cycle is the final gap cycle
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 6'd1;
      end
      S_END: begin
        if (pixel_finish) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vcnt_q   <= '0;
      pi_q     <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vcnt_q   <= vcnt_d;
      pi_q     <= pi_d;
    end
  end

  assign load      = (state_q == S_LOAD);
  assign pi_end    = (state_q == S_END);
  assign done      = (state_q == S_DONE);
  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE))
                     || (count_q != '0);
  assign err       = err_q;
  assign pi_length = pi_q[20:19];
  assign pi_fill   = pi_q[18];
  assign pi_msb    = pi_q[17];
  assign pi_low    = pi_q[16];
  assign pi_data   = pi_q[15:0];

endmodule

// File: tb/tb_sti_cmd_scheduler.sv
// Bench for sti_cmd_scheduler: transaction-timing reference model,
// directed table, hand sequences and randomized traffic.
`timescale 1ns/1ps
module tb_sti_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [20:0] cmd_a = '0, cmd_b = '0;
  logic        gnt_a, gnt_b;
  logic        flush = 1'b0;
  logic        so_valid = 1'b0;
  logic        pixel_finish = 1'b0;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low;
  logic        pi_end, busy, done, err;

  always #5 clk = ~clk;

  sti_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(rst_n),
    .req_a(req_a), .req_b(req_b),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .flush(flush), .so_valid(so_valid),
    .pixel_finish(pixel_finish),
    .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .busy(busy),
    .done(done), .err(err)
  );

  int n_checks = 0;
  int n_err = 0;

  // reference model state
  int          cyc;
  logic [20:0] q[$];
  bit          prio_b, flushed, in_end, in_done;
  int          idle_from, load_at, cur_n, vcount;
  logic [20:0] cur;
  bit          cur_drop, drop_next, err_m;

  int load_log[$];
  int n_gnt_b_obs;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prio_b = 0; flushed = 0; in_end = 0; in_done = 0;
    idle_from = 0; load_at = -1000; cur_n = 0; vcount = 0;
    cur = '0; cur_drop = 0; drop_next = 0; err_m = 0;
    cyc = 0;
  endtask

  // expectations from the timing rules: a pop in an idle cycle c gives
  // load at c+1, and the engine is idle again at load+N+2+GAP
  task automatic model_step();
    int sz;
    bit ok, ea, eb;
    sz = q.size();
    ok = (sz < DEPTH) && !flushed && !in_done;
    ea = ok && req_a && (!req_b || !prio_b);
    eb = ok && req_b && (!req_a || prio_b);
    check("gnt_a", gnt_a, ea);
    check("gnt_b", gnt_b, eb);
    check("load", load, cyc == load_at);
    check("busy", busy, (sz > 0) || (cyc < idle_from) || in_end);
    check("pi_end", pi_end, in_end);
    check("done", done, in_done);
    check("err", err, err_m);
    check("pi_fields", {pi_length, pi_fill, pi_msb, pi_low, pi_data}, cur);
    if (so_valid && cyc > load_at && cyc <= load_at + cur_n + 2)
      vcount++;
    if (cyc == load_at + cur_n + 2 && vcount != cur_n) err_m = 1;
    if (in_end && pixel_finish) begin
      in_end = 0;
      in_done = 1;
    end else if (!in_end && !in_done && cyc >= idle_from) begin
      if (sz > 0) begin
        cur = q.pop_front();
        cur_n = 8 * (int'(cur[20:19]) + 1);
        load_at = cyc + 1;
        idle_from = load_at + cur_n + 2 + GAP;
        vcount = 0;
        cur_drop = drop_next;
        drop_next = 0;
      end else if (flushed) begin
        in_end = 1;
      end
    end
    if (ea) q.push_back(cmd_a);
    else if (eb) q.push_back(cmd_b);
    if (ea || eb) prio_b = !prio_b;
    if (flush) flushed = 1;
    cyc++;
  endtask

  // transmitter model: N valid cycles at load+3..load+N+2
  task automatic drive_sv();
    so_valid = (cyc >= load_at + 3) && (cyc <= load_at + cur_n + 2)
               && !(cur_drop && cyc == load_at + cur_n + 2);
  endtask

  task automatic observe();
    if (load === 1'b1) load_log.push_back(cyc);
    if (gnt_b === 1'b1) n_gnt_b_obs++;
  endtask

  task automatic run_cycle();
    drive_sv();
    @(negedge clk);
    observe();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_check();
    rst_n = 1'b0;
    so_valid = 1'b0;
    #1;
    check("rst_load", load, 0);
    check("rst_gnt", {gnt_a, gnt_b}, 0);
    check("rst_pi", {pi_length, pi_fill, pi_msb, pi_low, pi_data}, 0);
    check("rst_pi_end", pi_end, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    req_a = 0;
    req_b = 0;
    while (!(q.size() == 0 && cyc >= idle_from) && k < max) begin
      run_cycle();
      k++;
    end
    n_checks++;
    if (k >= max) begin
      n_err++;
      $display("FAIL drain: no idle within %0d cycles", max);
    end
  endtask

  task automatic push_a(input logic [20:0] c);
    req_a = 1;
    cmd_a = c;
    run_cycle();
    req_a = 0;
  endtask

  typedef struct {
    logic ra, rb, ga, gb, ld;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int g;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    model_reset();
    @(posedge clk);
    #1;
    do_reset_check();

    // single 8-bit command
    repeat (10) run_cycle();
    load_log.delete();
    g = cyc;
    push_a(21'h010A5);
    drain(100);
    check("single_nloads", load_log.size(), 1);
    if (load_log.size() > 0)
      check("single_latency", load_log[0] - g, 2);
    check("single_pi_data", pi_data, 16'h10A5);
    check("single_err", err, 0);

    // back-to-back 16/24/32 bit lengths
    load_log.delete();
    push_a({2'd1, 3'b000, 16'h1616});
    push_a({2'd2, 3'b100, 16'h2424});
    push_a({2'd3, 3'b011, 16'h3232});
    drain(300);
    check("len_nloads", load_log.size(), 3);
    if (load_log.size() >= 3) begin
      check("len_space16", load_log[1] - load_log[0], 1 + 18 + GAP);
      check("len_space24", load_log[2] - load_log[1], 1 + 26 + GAP);
    end
    check("len_err", err, 0);

    // bit-count mismatch: 7 valid cycles for an 8-bit command
    load_log.delete();
    drop_next = 1;
    push_a({2'd0, 3'b010, 16'h0BAD});
    push_a({2'd0, 3'b000, 16'h600D});
    drain(100);
    check("mis_err", err, 1);
    check("mis_nloads", load_log.size(), 2);
    check("mis_next_data", pi_data, 16'h600D);

    // contention from a fresh reset, table driven
    do_reset_check();
    for (int i = 0; i < 7; i++) begin
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      cmd_a = {2'd3, 3'b000, 16'hA000 + 16'(i)};
      cmd_b = {2'd3, 3'b010, 16'hB000 + 16'(i)};
      drive_sv();
      @(negedge clk);
      check($sformatf("tbl%0d_gnt_a", i), gnt_a, tbl[i].ga);
      check($sformatf("tbl%0d_gnt_b", i), gnt_b, tbl[i].gb);
      check($sformatf("tbl%0d_load", i), load, tbl[i].ld);
      observe();
      model_step();
      @(posedge clk);
      #1;
    end
    drain(400);
    check("cont_err", err, 0);

    // randomized traffic
    do_reset_check();
    for (int i = 0; i < 800; i++) begin
      req_a = ($urandom_range(0, 2) == 0);
      req_b = ($urandom_range(0, 2) == 0);
      cmd_a = 21'($urandom);
      cmd_b = 21'($urandom);
      pixel_finish = ($urandom_range(0, 15) == 0);
      drop_next = ($urandom_range(0, 11) == 0);
      run_cycle();
    end
    pixel_finish = 0;
    drop_next = 0;
    drain(400);

    // reset in the middle of a 32-bit HOLD with two queued
    do_reset_check();
    push_a({2'd3, 3'b001, 16'hC001});
    push_a({2'd3, 3'b001, 16'hC002});
    push_a({2'd3, 3'b001, 16'hC003});
    repeat (9) run_cycle();
    do_reset_check();
    load_log.delete();
    repeat (30) run_cycle();
    check("postrst_nloads", load_log.size(), 0);
    check("postrst_busy", busy, 0);

    // flush with requester B still asking
    load_log.delete();
    push_a({2'd0, 3'b000, 16'hF001});
    push_a({2'd0, 3'b000, 16'hF002});
    req_a = 1;
    cmd_a = {2'd0, 3'b000, 16'hF003};
    flush = 1;
    run_cycle();
    req_a = 0;
    flush = 0;
    req_b = 1;
    cmd_b = {2'd0, 3'b000, 16'hBEEF};
    n_gnt_b_obs = 0;
    pixel_finish = 1;
    run_cycle();
    pixel_finish = 0;
    g = 0;
    while (!in_end && g < 200) begin
      run_cycle();
      g++;
    end
    check("flush_end_reached", g < 200, 1);
    repeat (3) run_cycle();
    check("flush_pi_end", pi_end, 1);
    pixel_finish = 1;
    run_cycle();
    pixel_finish = 0;
    check("flush_done", done, 1);
    check("flush_pi_end_low", pi_end, 0);
    repeat (3) run_cycle();
    req_b = 0;
    check("flush_nloads", load_log.size(), 3);
    check("flush_no_gnt", n_gnt_b_obs, 0);
    check("flush_last_data", pi_data, 16'hF003);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
